// File: rtl/systolic_seq_ctrl_if.sv
// Stream and array-edge signals of the systolic sequencer, grouped so the
// controller (master) and its environment (slave) see mirrored directions.
interface systolic_seq_ctrl_if #(
  parameter int N  = 4,
  parameter int DW = 32
) ();
  logic [DW-1:0]   s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [N*DW-1:0] arr_row;
  logic [N*DW-1:0] arr_col;
  logic            arr_in_valid;
  logic [N*DW-1:0] arr_result;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready, arr_result,
    output s_tready, m_tdata, m_tvalid, m_tlast, arr_row, arr_col, arr_in_valid
  );
  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready, arr_result,
    input  s_tready, m_tdata, m_tvalid, m_tlast, arr_row, arr_col, arr_in_valid
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N systolic array: loads A/B, feeds skewed edges,
// captures the bottom-row drain and streams C out row-major.
module systolic_seq_lane #(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter int LANE = 0,
  parameter int CW   = 6
) (
  input  logic                   en,
  input  logic [CW-1:0]          k,
  input  logic [N*N-1:0][DW-1:0] a,
  input  logic [N*N-1:0][DW-1:0] b,
  output logic [DW-1:0]          row,
  output logic [DW-1:0]          col
);
  localparam int IW = $clog2(N*N);
  int d;

  // Row lane i and column lane j share the same skew (k - lane), so one
  // window test serves both edges.
  always_comb begin
    row = '0;
    col = '0;
    d   = int'(k) - LANE;
    if (en && d >= 0 && d < N) begin
      row = a[IW'(LANE*N + d)];
      col = b[IW'(d*N + LANE)];
    end
  end
endmodule

module systolic_seq_ctrl #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  systolic_seq_ctrl_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len
);
  localparam int NN = N*N;
  localparam int IW = $clog2(NN);
  localparam int CW = $clog2(2*NN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(2*NN - 1);
  localparam logic [CW-1:0] FEED_END  = CW'(3*N - 3);
  localparam logic [CW-1:0] DRAIN_END = CW'(N - 1);
  localparam logic [CW-1:0] NN_C      = CW'(NN);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, SEND} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [NN-1:0][DW-1:0]  a_buf, b_buf, c_buf;
  logic [N-1:0][DW-1:0]   row_l, col_l;
  logic                   beat, xfer;

  assign beat              = (state == LOAD) && bus.s_tvalid;
  assign xfer              = bus.m_tvalid && bus.m_tready;
  assign bus.s_tready      = (state == LOAD);
  assign bus.arr_in_valid  = (state == FEED);
  assign busy              = (state != IDLE);
  assign bus.arr_row       = row_l;
  assign bus.arr_col       = col_l;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.s_tvalid) state_nxt = LOAD;
      LOAD:  if (beat) begin
               if (cnt == LAST_BEAT)  state_nxt = FEED;
               else if (bus.s_tlast)  state_nxt = IDLE;
             end
      FEED:  if (cnt == FEED_END)  state_nxt = DRAIN;
      DRAIN: if (cnt == DRAIN_END) state_nxt = SEND;
      SEND:  if (xfer && bus.m_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt          <= '0;
      a_buf        <= '0;
      b_buf        <= '0;
      c_buf        <= '0;
      bus.m_tdata  <= '0;
      bus.m_tvalid <= 1'b0;
      bus.m_tlast  <= 1'b0;
      done         <= 1'b0;
      err_len      <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_len <= 1'b0;
      case (state)
        IDLE: cnt <= '0;
        LOAD: if (beat) begin
          if (cnt < NN_C) a_buf[IW'(cnt)]        <= bus.s_tdata;
          else            b_buf[IW'(cnt - NN_C)] <= bus.s_tdata;
          if (cnt == LAST_BEAT) cnt <= '0;
          else if (bus.s_tlast) begin
            err_len <= 1'b1;
            cnt     <= '0;
          end else cnt <= cnt + 1'b1;
        end
        FEED: cnt <= (cnt == FEED_END) ? '0 : cnt + 1'b1;
        // Bottom row exits the array first, so drain cycle d lands in row N-1-d.
        DRAIN: begin
          for (int j = 0; j < N; j++)
            c_buf[IW'((N-1-int'(cnt))*N + j)] <= bus.arr_result[j*DW +: DW];
          cnt <= (cnt == DRAIN_END) ? '0 : cnt + 1'b1;
        end
        // Single output register: reload whenever empty or being consumed.
        SEND: if (!bus.m_tvalid || bus.m_tready) begin
          if (cnt < NN_C) begin
            bus.m_tdata  <= c_buf[IW'(cnt)];
            bus.m_tvalid <= 1'b1;
            bus.m_tlast  <= (cnt == NN_C - 1'b1);
            cnt          <= cnt + 1'b1;
          end else begin
            bus.m_tdata  <= '0;
            bus.m_tvalid <= 1'b0;
            bus.m_tlast  <= 1'b0;
            if (bus.m_tlast) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    systolic_seq_lane #(.N(N), .DW(DW), .LANE(g), .CW(CW)) u_lane (
      .en  (state == FEED),
      .k   (cnt),
      .a   (a_buf),
      .b   (b_buf),
      .row (row_l[g]),
      .col (col_l[g])
    );
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench: operand frames in, array edge checked and emulated,
// results compared against a matrix-product model.
module tb_systolic_seq_ctrl;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NN = N*N;

  typedef struct { logic [DW-1:0] d; bit l; } exp_t;

  logic i_clk, i_rst, busy, done, err_len;
  systolic_seq_ctrl_if #(.N(N), .DW(DW)) bus ();

  systolic_seq_ctrl #(.N(N), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus.master),
    .busy(busy), .done(done), .err_len(err_len)
  );

  int total = 0, bad = 0;
  int cyc = 0, last_beat_cyc = 0;
  int done_cnt = 0, err_cnt = 0;
  bit lat_armed = 0, rdy_mode = 0;
  logic [DW-1:0] A [NN];
  logic [DW-1:0] B [NN];
  logic [DW-1:0] Cm [NN];
  exp_t sb [$];

  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_ops(input int mode);
    logic [DW-1:0] s;
    for (int i = 0; i < NN; i++) begin
      case (mode)
        0:       begin A[i] = (i/N == i%N) ? 1 : 0; B[i] = DW'(i); end
        1:       begin A[i] = 1; B[i] = 1; end
        default: begin A[i] = $urandom; B[i] = $urandom; end
      endcase
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = '0;
        for (int k = 0; k < N; k++) s += A[r*N+k] * B[k*N+c];
        Cm[r*N+c] = s;
      end
  endtask

  // Called at a negedge; returns at the negedge after the last accepted beat.
  task automatic send_frame(input int err_beat, input bit drop_last);
    int t;
    exp_t e;
    for (int b = 0; b < 2*NN; b++) begin
      bus.s_tdata  = (b < NN) ? A[b] : B[b-NN];
      bus.s_tvalid = 1'b1;
      bus.s_tlast  = (b == err_beat) || (b == 2*NN-1 && !drop_last);
      t = 0;
      while (!bus.s_tready && t < 50) begin @(negedge i_clk); t++; end
      if (t == 50) begin
        chk("s_tready_timeout", 0, 1);
        bus.s_tvalid = 0; bus.s_tlast = 0;
        return;
      end
      if (b == 2*NN-1) begin last_beat_cyc = cyc; lat_armed = 1; end
      @(negedge i_clk);
      if (b == err_beat) begin
        bus.s_tvalid = 0; bus.s_tlast = 0;
        chk("err_len_pulse", err_len, 1);
        chk("err_to_idle", busy, 0);
        return;
      end
    end
    bus.s_tvalid = 0; bus.s_tlast = 0;
    for (int i = 0; i < NN; i++) begin
      e.d = Cm[i]; e.l = (i == NN-1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_frame(input int exp_done);
    int t = 0;
    while ((sb.size() != 0 || done_cnt < exp_done) && t < 400) begin
      @(negedge i_clk); t++;
    end
    chk("frame_timeout", t < 400, 1);
    chk("done_cnt", done_cnt, exp_done);
  endtask

  // Result-side monitor and m_tready driver.
  bit stall_pend = 0, done_exp = 0;
  logic [DW-1:0] held;
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst) begin
      bus.m_tready = 0; stall_pend = 0; done_exp = 0;
    end else begin
      bus.m_tready = rdy_mode ? cyc[0] : 1'b1;
      if (done) done_cnt++;
      if (err_len) err_cnt++;
      if (done_exp) chk("done_after_last", done, 1);
      else if (done) chk("done_spurious", done, 0);
      done_exp = 0;
      if (stall_pend) begin
        chk("hold_valid", bus.m_tvalid, 1);
        chk("hold_data", bus.m_tdata, held);
      end
      stall_pend = 0;
      if (bus.m_tvalid) begin
        if (lat_armed) begin
          chk("latency", cyc - last_beat_cyc, 4*N);
          lat_armed = 0;
        end
        if (sb.size() == 0) chk("extra_beat", bus.m_tvalid, 0);
        else if (bus.m_tready) begin
          e = sb.pop_front();
          chk("m_tdata", bus.m_tdata, e.d);
          chk("m_tlast", bus.m_tlast, e.l);
          if (e.l) done_exp = 1;
        end else begin
          stall_pend = 1; held = bus.m_tdata;
        end
      end
    end
  end

  // Array model: checks the skewed edge and plays back C bottom row first.
  bit in_feed = 0;
  int fk = 0, dd = 0;
  always @(negedge i_clk) begin
    logic [DW-1:0] er, ec;
    int kk;
    if (!busy) begin
      in_feed = 0; fk = 0; dd = 0; bus.arr_result = '0;
    end else if (bus.arr_in_valid) begin
      if (!in_feed) fk = 0;
      for (int i = 0; i < N; i++) begin
        kk = fk - i;
        er = (kk >= 0 && kk < N) ? A[i*N+kk] : '0;
        ec = (kk >= 0 && kk < N) ? B[kk*N+i] : '0;
        chk($sformatf("feed_row%0d_k%0d", i, fk), bus.arr_row[i*DW +: DW], er);
        chk($sformatf("feed_col%0d_k%0d", i, fk), bus.arr_col[i*DW +: DW], ec);
      end
      fk++; in_feed = 1; dd = 0; bus.arr_result = '0;
    end else if (in_feed) begin
      if (dd == 0) chk("feed_len", fk, 3*N-2);
      chk("drain_row_zero", bus.arr_row, 0);
      chk("drain_col_zero", bus.arr_col, 0);
      for (int j = 0; j < N; j++) bus.arr_result[j*DW +: DW] = Cm[(N-1-dd)*N + j];
      dd++;
      if (dd == N) in_feed = 0;
    end else bus.arr_result = '0;
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_s_tready"}, bus.s_tready, 0);
    chk({tag, "_m_tvalid"}, bus.m_tvalid, 0);
    chk({tag, "_m_tlast"}, bus.m_tlast, 0);
    chk({tag, "_m_tdata"}, bus.m_tdata, 0);
    chk({tag, "_in_valid"}, bus.arr_in_valid, 0);
    chk({tag, "_arr_row"}, bus.arr_row, 0);
    chk({tag, "_arr_col"}, bus.arr_col, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_len"}, err_len, 0);
  endtask

  initial begin
    i_rst = 0;
    bus.s_tdata = '0; bus.s_tvalid = 0; bus.s_tlast = 0;
    repeat (3) @(negedge i_clk);
    chk_quiet("rst");
    i_rst = 1;
    @(negedge i_clk);

    set_ops(0); send_frame(-1, 0); wait_frame(1);   // identity: results 0..15
    set_ops(1); send_frame(-1, 0); wait_frame(2);   // all ones: results 4
    rdy_mode = 1;
    set_ops(2); send_frame(-1, 0); wait_frame(3);   // back-pressure
    rdy_mode = 0;

    set_ops(2); send_frame(20, 0);                  // early s_tlast
    repeat (30) @(negedge i_clk);
    chk("err_cnt_after_err", err_cnt, 1);
    chk("done_cnt_after_err", done_cnt, 3);
    set_ops(2); send_frame(-1, 0); wait_frame(4);

    set_ops(2); send_frame(-1, 1); wait_frame(5);   // final beat without s_tlast
    chk("err_cnt_no_last", err_cnt, 1);

    set_ops(2); send_frame(-1, 0);                  // now in FEED cycle 0
    repeat (3) @(negedge i_clk);
    chk("in_feed_before_rst", bus.arr_in_valid, 1);
    #2 i_rst = 0;
    #1 chk_quiet("async_rst");
    sb.delete(); lat_armed = 0;
    repeat (2) @(negedge i_clk);
    i_rst = 1;
    @(negedge i_clk);
    chk("done_cnt_after_rst", done_cnt, 5);
    set_ops(2); send_frame(-1, 0); wait_frame(6);
    chk("err_cnt_final", err_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
